// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I decode constants
// Purpose: opcode, funct3 and br_type bit-index constants for branch decode.
// Ports: none (package).
package rv_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int BR_W    = 6;
    localparam int BR_BEQ  = 0;
    localparam int BR_BNE  = 1;
    localparam int BR_BLT  = 2;
    localparam int BR_BGE  = 3;
    localparam int BR_BLTU = 4;
    localparam int BR_BGEU = 5;

endpackage

// File: rtl/b_fields_comb.sv
// rtl/b_fields_comb.sv - combinational B-type field split and branch classify
// Purpose: positional field extraction, B-immediate assembly, condition decode.
// Ports:
//   i_word       32-bit raw instruction
//   o_imm_msb..o_opcode  positional fields
//   o_imm_b      sign-extended branch offset
//   o_br_type    one-hot branch condition (zero if not a legal branch)
//   o_is_branch  branch opcode with legal funct3
//   o_illegal    branch opcode with reserved funct3 (010/011)
module b_fields_comb
    import rv_pkg::*;
(
    input  logic [31:0]     i_word,
    output logic [6:0]      o_imm_msb,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rs1,
    output logic [2:0]      o_funct3,
    output logic [4:0]      o_imm_lsb,
    output logic [6:0]      o_opcode,
    output logic [31:0]     o_imm_b,
    output logic [BR_W-1:0] o_br_type,
    output logic            o_is_branch,
    output logic            o_illegal
);

    logic w_is_opc;

    assign o_imm_msb = i_word[31:25];
    assign o_rs2     = i_word[24:20];
    assign o_rs1     = i_word[19:15];
    assign o_funct3  = i_word[14:12];
    assign o_imm_lsb = i_word[11:7];
    assign o_opcode  = i_word[6:0];

    // Offset bit 12 lives in iw[31] and bit 11 in iw[7]; bit 0 is implicit zero.
    assign o_imm_b = {{19{i_word[31]}}, i_word[31], i_word[7],
                      i_word[30:25], i_word[11:8], 1'b0};

    assign w_is_opc = (i_word[6:0] == OPC_BRANCH);

    always_comb begin
        o_br_type = '0;
        if (w_is_opc) begin
            case (i_word[14:12])
                F3_BEQ:  o_br_type[BR_BEQ]  = 1'b1;
                F3_BNE:  o_br_type[BR_BNE]  = 1'b1;
                F3_BLT:  o_br_type[BR_BLT]  = 1'b1;
                F3_BGE:  o_br_type[BR_BGE]  = 1'b1;
                F3_BLTU: o_br_type[BR_BLTU] = 1'b1;
                F3_BGEU: o_br_type[BR_BGEU] = 1'b1;
                default: o_br_type = '0;
            endcase
        end
    end

    // Any set br_type bit implies a legal branch; reserved funct3 leaves it zero.
    assign o_is_branch = |o_br_type;
    assign o_illegal   = w_is_opc && (i_word[14:13] == 2'b01);

endmodule

// File: rtl/inst_b_dec.sv
// rtl/inst_b_dec.sv - registered RV32I B-type instruction decoder
// Purpose: one-cycle registered decode of branch fields, offset and condition.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          instruction_word valid this cycle
//   instruction_word  raw 32-bit instruction
//   out_valid         registered in_valid
//   imm_MSB, rs2, rs1, funct3, imm_LSB, opcode  registered positional fields
//   imm_b             registered sign-extended branch offset
//   br_type           registered one-hot condition
//   is_branch, illegal  registered classification, qualified by in_valid
module inst_b_dec
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [31:0]     instruction_word,
    output logic            out_valid,
    output logic [6:0]      imm_MSB,
    output logic [4:0]      rs2,
    output logic [4:0]      rs1,
    output logic [2:0]      funct3,
    output logic [4:0]      imm_LSB,
    output logic [6:0]      opcode,
    output logic [31:0]     imm_b,
    output logic [BR_W-1:0] br_type,
    output logic            is_branch,
    output logic            illegal
);

    logic [6:0]      w_imm_msb;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rs1;
    logic [2:0]      w_funct3;
    logic [4:0]      w_imm_lsb;
    logic [6:0]      w_opcode;
    logic [31:0]     w_imm_b;
    logic [BR_W-1:0] w_br_type;
    logic            w_is_branch;
    logic            w_illegal;

    logic            r_valid;
    logic [6:0]      r_imm_msb;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rs1;
    logic [2:0]      r_funct3;
    logic [4:0]      r_imm_lsb;
    logic [6:0]      r_opcode;
    logic [31:0]     r_imm_b;
    logic [BR_W-1:0] r_br_type;
    logic            r_is_branch;
    logic            r_illegal;

    b_fields_comb u_fields (
        .i_word      (instruction_word),
        .o_imm_msb   (w_imm_msb),
        .o_rs2       (w_rs2),
        .o_rs1       (w_rs1),
        .o_funct3    (w_funct3),
        .o_imm_lsb   (w_imm_lsb),
        .o_opcode    (w_opcode),
        .o_imm_b     (w_imm_b),
        .o_br_type   (w_br_type),
        .o_is_branch (w_is_branch),
        .o_illegal   (w_illegal)
    );

    // Fields load every cycle regardless of in_valid; only the two flags are
    // qualified so a stale word can never look like a branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_imm_msb   <= '0;
            r_rs2       <= '0;
            r_rs1       <= '0;
            r_funct3    <= '0;
            r_imm_lsb   <= '0;
            r_opcode    <= '0;
            r_imm_b     <= '0;
            r_br_type   <= '0;
            r_is_branch <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_valid     <= in_valid;
            r_imm_msb   <= w_imm_msb;
            r_rs2       <= w_rs2;
            r_rs1       <= w_rs1;
            r_funct3    <= w_funct3;
            r_imm_lsb   <= w_imm_lsb;
            r_opcode    <= w_opcode;
            r_imm_b     <= w_imm_b;
            r_br_type   <= w_br_type;
            r_is_branch <= in_valid & w_is_branch;
            r_illegal   <= in_valid & w_illegal;
        end
    end

    assign out_valid = r_valid;
    assign imm_MSB   = r_imm_msb;
    assign rs2       = r_rs2;
    assign rs1       = r_rs1;
    assign funct3    = r_funct3;
    assign imm_LSB   = r_imm_lsb;
    assign opcode    = r_opcode;
    assign imm_b     = r_imm_b;
    assign br_type   = r_br_type;
    assign is_branch = r_is_branch;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_inst_b_dec.sv
// tb/tb_inst_b_dec.sv - self-checking bench for inst_b_dec
module tb_inst_b_dec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instruction_word;
    logic        out_valid;
    logic [6:0]  imm_MSB;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  imm_LSB;
    logic [6:0]  opcode;
    logic [31:0] imm_b;
    logic [5:0]  br_type;
    logic        is_branch;
    logic        illegal;

    int vectors;
    int miscompares;

    inst_b_dec dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .instruction_word (instruction_word),
        .out_valid        (out_valid),
        .imm_MSB          (imm_MSB),
        .rs2              (rs2),
        .rs1              (rs1),
        .funct3           (funct3),
        .imm_LSB          (imm_LSB),
        .opcode           (opcode),
        .imm_b            (imm_b),
        .br_type          (br_type),
        .is_branch        (is_branch),
        .illegal          (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [72:0] obs;
    assign obs = {out_valid, imm_MSB, rs2, rs1, funct3, imm_LSB, opcode,
                  imm_b, br_type, is_branch, illegal};

    // Reference: offset computed as a signed sum of weighted bit groups,
    // condition looked up from the funct3 table.
    function automatic logic [72:0] model(input logic v, input logic [31:0] w);
        int          off;
        logic [31:0] imm;
        logic [5:0]  br;
        logic        isb;
        logic        ill;
        bit          opc_ok;
        off = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0)
            + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        imm = off;
        opc_ok = (w[6:0] == 7'h63);
        br = 6'd0;
        if (opc_ok) begin
            case (w[14:12])
                3'd0: br = 6'd1;
                3'd1: br = 6'd2;
                3'd4: br = 6'd4;
                3'd5: br = 6'd8;
                3'd6: br = 6'd16;
                3'd7: br = 6'd32;
                default: br = 6'd0;
            endcase
        end
        isb = v && opc_ok && (w[14:12] != 3'd2) && (w[14:12] != 3'd3);
        ill = v && opc_ok && ((w[14:12] == 3'd2) || (w[14:12] == 3'd3));
        return {v, w[31:25], w[24:20], w[19:15], w[14:12], w[11:7], w[6:0],
                imm, br, isb, ill};
    endfunction

    task automatic check(input string tag, input logic [72:0] o, input logic [72:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Drive at negedge, sample 1 time unit after the following posedge.
    task automatic step(input string tag, input logic v, input logic [31:0] w);
        @(negedge clk);
        in_valid = v;
        instruction_word = w;
        @(posedge clk);
        #1;
        check(tag, obs, model(v, w));
    endtask

    localparam logic [31:0] W_BGEU = 32'b0000111_10101_01101_111_01101_1100011;
    localparam logic [31:0] W_BLT  = 32'b0000111_10101_01101_100_01101_1100011;

    initial begin
        logic [31:0] w;
        logic        v;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        in_valid = 1'b1;
        instruction_word = W_BGEU;

        // Reset held with live input: everything stays zero.
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", obs, 73'd0);

        // Release with in_valid low.
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_valid", {72'd0, out_valid}, 73'd0);
        check("post_reset_flags", {71'd0, is_branch, illegal}, 73'd0);

        // BGEU then BLT back-to-back.
        step("bgeu", 1'b1, W_BGEU);
        check("bgeu_imm", {41'd0, imm_b}, {41'd0, 32'h0000_08EC});
        check("bgeu_br", {67'd0, br_type}, {67'd0, 6'b100000});
        check("bgeu_fields", {41'd0, imm_MSB, rs2, rs1, funct3, imm_LSB, opcode},
              {41'd0, 7'h07, 5'd21, 5'd13, 3'd7, 5'd13, 7'h63});
        step("blt", 1'b1, W_BLT);
        check("blt_br_valid", {66'd0, out_valid, br_type}, {66'd0, 1'b1, 6'b000100});
        check("blt_imm", {41'd0, imm_b}, {41'd0, 32'h0000_08EC});

        // Negative offset, BEQ.
        step("neg_off", 1'b1, 32'hFE00_0EE3);
        check("neg_imm", {41'd0, imm_b}, {41'd0, 32'hFFFF_FFFC});
        check("neg_br_rs", {57'd0, br_type, rs1, rs2}, {57'd0, 6'b000001, 10'd0});

        // Reserved funct3 010 and 011.
        step("illegal_010", 1'b1, 32'h1234_2063);
        check("illegal_flags", {65'd0, is_branch, illegal, br_type}, {65'd0, 2'b01, 6'd0});
        step("illegal_011", 1'b1, 32'h8765_3063);

        // Non-branch ADDI.
        step("addi", 1'b1, 32'h0000_0013);
        check("addi_flags", {65'd0, is_branch, illegal, br_type}, 73'd0);

        // Legal branch with in_valid low: flags suppressed, fields still load.
        step("branch_invalid", 1'b0, W_BGEU);
        check("invalid_flags", {70'd0, out_valid, is_branch, illegal}, 73'd0);

        // Randomized stream, half the words forced onto the branch opcode.
        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[6:0] = 7'h63;
            v = ($urandom_range(0, 3) != 0);
            step("random", v, w);
        end

        // Asynchronous reset mid-stream: clears without a clock edge.
        step("pre_async", 1'b1, W_BGEU);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", obs, 73'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("after_async_idle", {72'd0, out_valid}, 73'd0);
        step("after_async_first", 1'b1, W_BLT);
        step("after_async_second", 1'b1, 32'hFE00_0EE3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
